// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with a two-entry skid buffer.
// Carries a control bundle plus NUM_CH data channels, with flush and stall count.
module pipe_stage_skid #(
    parameter int                 DATA_W   = 32,
    parameter int                 NUM_CH   = 4,
    parameter int                 CTRL_W   = 4,
    parameter logic [CTRL_W-1:0]  CTRL_BUB = '0
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Flush,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic [CTRL_W-1:0]        In_Ctrl,
    input  logic [NUM_CH*DATA_W-1:0] In_Data,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic [CTRL_W-1:0]        Out_Ctrl,
    output logic [NUM_CH*DATA_W-1:0] Out_Data,
    output logic [1:0]               Occupancy,
    output logic [15:0]              Stall_Cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic main_valid;
    logic skid_valid;

    logic [CTRL_W-1:0]        main_ctrl;
    logic [CTRL_W-1:0]        skid_ctrl;
    logic [NUM_CH*DATA_W-1:0] main_data;
    logic [NUM_CH*DATA_W-1:0] skid_data;

    logic push;
    logic pop;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    // In_Ready comes only from the skid valid flop, never from Out_Ready.
    assign push = In_Valid & ~skid_valid;
    assign pop  = main_valid & Out_Ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (Flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        load_main_in = 1'b1;
                    end else if (push) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            main_valid <= (state_nxt != EMPTY);
            skid_valid <= (state_nxt == FULL);
        end
    end

    // Flush only scrubs control; stale data is harmless behind a bubble.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            main_ctrl <= CTRL_BUB;
            skid_ctrl <= CTRL_BUB;
            main_data <= '0;
            skid_data <= '0;
        end else if (Flush) begin
            main_ctrl <= CTRL_BUB;
            skid_ctrl <= CTRL_BUB;
        end else begin
            if (load_main_in) begin
                main_ctrl <= In_Ctrl;
                main_data <= In_Data;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= In_Ctrl;
                skid_data <= In_Data;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Stall_Cnt <= 16'h0000;
        end else if (main_valid && !Out_Ready && Stall_Cnt != 16'hFFFF) begin
            Stall_Cnt <= Stall_Cnt + 16'h0001;
        end
    end

    assign In_Ready  = ~skid_valid;
    assign Out_Valid = main_valid;
    assign Out_Ctrl  = main_valid ? main_ctrl : CTRL_BUB;
    assign Out_Data  = main_data;
    assign Occupancy = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: default build plus a narrow
// instance with a non-zero bubble value.
module tb_pipe_stage_skid;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_ctrl;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_ctrl;
    logic [127:0] out_data;
    logic [1:0]   occ;
    logic [15:0]  stall_cnt;

    logic         s_flush;
    logic         s_iv;
    logic         s_irdy;
    logic [0:0]   s_ictrl;
    logic [7:0]   s_idata;
    logic         s_ov;
    logic         s_ordy;
    logic [0:0]   s_octrl;
    logic [7:0]   s_odata;
    logic [1:0]   s_occ;
    logic [15:0]  s_stall;

    int checks   = 0;
    int failures = 0;

    pipe_stage_skid dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .Flush     (flush),
        .In_Valid  (in_valid),
        .In_Ready  (in_ready),
        .In_Ctrl   (in_ctrl),
        .In_Data   (in_data),
        .Out_Valid (out_valid),
        .Out_Ready (out_ready),
        .Out_Ctrl  (out_ctrl),
        .Out_Data  (out_data),
        .Occupancy (occ),
        .Stall_Cnt (stall_cnt)
    );

    pipe_stage_skid #(
        .DATA_W   (8),
        .NUM_CH   (1),
        .CTRL_W   (1),
        .CTRL_BUB (1'b1)
    ) dut_s (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .Flush     (s_flush),
        .In_Valid  (s_iv),
        .In_Ready  (s_irdy),
        .In_Ctrl   (s_ictrl),
        .In_Data   (s_idata),
        .Out_Valid (s_ov),
        .Out_Ready (s_ordy),
        .Out_Ctrl  (s_octrl),
        .Out_Data  (s_odata),
        .Occupancy (s_occ),
        .Stall_Cnt (s_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         flush;
        logic         iv;
        logic [3:0]   ictrl;
        logic [127:0] idata;
        logic         ordy;
        logic         ov;
        logic [3:0]   octrl;
        logic [127:0] odata;
        logic [1:0]   occ;
        logic         irdy;
        logic [15:0]  stall;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [127:0] mk(input int i);
        logic [127:0] r;
        for (int k = 0; k < 4; k++)
            r[k*32 +: 32] = 32'h1000 + 32'(i) + (32'(k) << 16);
        return r;
    endfunction

    function automatic void add(
        input logic fl, input logic iv, input logic [3:0] ic,
        input logic [127:0] id, input logic ordy,
        input logic ov, input logic [3:0] oc, input logic [127:0] od,
        input logic [1:0] oq, input logic irdy, input logic [15:0] st
    );
        vec_t v;
        v.flush = fl;
        v.iv    = iv;
        v.ictrl = ic;
        v.idata = id;
        v.ordy  = ordy;
        v.ov    = ov;
        v.octrl = oc;
        v.odata = od;
        v.occ   = oq;
        v.irdy  = irdy;
        v.stall = st;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = 4'h0;
        in_data   = '0;
        out_ready = 1'b0;
        s_flush   = 1'b0;
        s_iv      = 1'b0;
        s_ictrl   = 1'b0;
        s_idata   = 8'h00;
        s_ordy    = 1'b0;

        // streaming
        for (int i = 0; i < 8; i++)
            add(0, 1, 4'b0001, mk(i), 1, 1, 4'b0001, mk(i), 1, 1, 0);
        add(0, 0, 4'h0, '0, 1, 0, 4'h0, '0, 0, 1, 0);
        // backpressure A, B, C
        add(0, 1, 4'b1010, mk(16), 0, 1, 4'b1010, mk(16), 1, 1, 0);
        add(0, 1, 4'b0110, mk(17), 0, 1, 4'b1010, mk(16), 2, 0, 1);
        add(0, 1, 4'b1100, mk(18), 0, 1, 4'b1010, mk(16), 2, 0, 2);
        add(0, 1, 4'b1100, mk(18), 1, 1, 4'b0110, mk(17), 1, 1, 2);
        add(0, 1, 4'b1100, mk(18), 1, 1, 4'b1100, mk(18), 1, 1, 2);
        add(0, 0, 4'h0, '0, 1, 0, 4'h0, '0, 0, 1, 2);
        // flush while full, D offered
        add(0, 1, 4'b0011, mk(20), 0, 1, 4'b0011, mk(20), 1, 1, 2);
        add(0, 1, 4'b0101, mk(21), 0, 1, 4'b0011, mk(20), 2, 0, 3);
        add(1, 1, 4'b1111, mk(22), 0, 0, 4'h0, '0, 0, 1, 4);
        add(0, 0, 4'h0, '0, 1, 0, 4'h0, '0, 0, 1, 4);
        add(0, 0, 4'h0, '0, 1, 0, 4'h0, '0, 0, 1, 4);
        // flush while one, ready high, D offered with In_Ready=1
        add(0, 1, 4'b0011, mk(23), 1, 1, 4'b0011, mk(23), 1, 1, 4);
        add(1, 1, 4'b1111, mk(22), 1, 0, 4'h0, '0, 0, 1, 4);
        add(0, 0, 4'h0, '0, 1, 0, 4'h0, '0, 0, 1, 4);

        #1;
        chk("rst_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_ctrl", 128'(out_ctrl), 128'(4'h0));
        chk("rst_data", out_data, '0);
        chk("rst_occ", 128'(occ), 128'(2'd0));
        chk("rst_ready", 128'(in_ready), 128'(1'b1));
        chk("rst_stall", 128'(stall_cnt), 128'(16'h0));
        chk("rst_s_ctrl", 128'(s_octrl), 128'(1'b1));

        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            flush     = vecs[i].flush;
            in_valid  = vecs[i].iv;
            in_ctrl   = vecs[i].ictrl;
            in_data   = vecs[i].idata;
            out_ready = vecs[i].ordy;
            tick();
            chk($sformatf("v%0d_valid", i), 128'(out_valid), 128'(vecs[i].ov));
            chk($sformatf("v%0d_ctrl", i), 128'(out_ctrl), 128'(vecs[i].octrl));
            chk($sformatf("v%0d_occ", i), 128'(occ), 128'(vecs[i].occ));
            chk($sformatf("v%0d_ready", i), 128'(in_ready), 128'(vecs[i].irdy));
            chk($sformatf("v%0d_stall", i), 128'(stall_cnt), 128'(vecs[i].stall));
            if (vecs[i].ov)
                chk($sformatf("v%0d_data", i), out_data, vecs[i].odata);
        end
        flush    = 1'b0;
        in_valid = 1'b0;

        // narrow instance with CTRL_BUB=1
        s_iv = 1'b1; s_ictrl = 1'b0; s_idata = 8'hA5; s_ordy = 1'b1;
        tick();
        chk("s_valid0", 128'(s_ov), 128'(1'b1));
        chk("s_data0", 128'(s_odata), 128'(8'hA5));
        chk("s_ctrl0", 128'(s_octrl), 128'(1'b0));
        s_ictrl = 1'b1; s_idata = 8'h5A;
        tick();
        chk("s_data1", 128'(s_odata), 128'(8'h5A));
        chk("s_ctrl1", 128'(s_octrl), 128'(1'b1));
        s_iv = 1'b0;
        tick();
        chk("s_empty_valid", 128'(s_ov), 128'(1'b0));
        chk("s_empty_ctrl", 128'(s_octrl), 128'(1'b1));
        s_iv = 1'b1; s_ictrl = 1'b0; s_idata = 8'hFF; s_ordy = 1'b0;
        tick();
        chk("s_data2", 128'(s_odata), 128'(8'hFF));
        chk("s_ctrl2", 128'(s_octrl), 128'(1'b0));
        s_flush = 1'b1; s_idata = 8'h00;
        tick();
        chk("s_flush_valid", 128'(s_ov), 128'(1'b0));
        chk("s_flush_ctrl", 128'(s_octrl), 128'(1'b1));
        chk("s_flush_occ", 128'(s_occ), 128'(2'd0));
        chk("s_flush_stall", 128'(s_stall), 128'(16'd1));
        s_flush = 1'b0; s_iv = 1'b0;
        tick();
        chk("s_post_flush_valid", 128'(s_ov), 128'(1'b0));

        // asynchronous reset mid-cycle while full
        in_valid = 1'b1; in_ctrl = 4'b1010; in_data = mk(30); out_ready = 1'b0;
        tick();
        in_ctrl = 4'b0110; in_data = mk(31);
        tick();
        chk("pre_rst_occ", 128'(occ), 128'(2'd2));
        in_valid = 1'b0;
        // Out_Ready must not reach In_Ready combinationally
        out_ready = 1'b1;
        #1;
        chk("ready_no_comb", 128'(in_ready), 128'(1'b0));
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid), 128'(1'b0));
        chk("arst_ctrl", 128'(out_ctrl), 128'(4'h0));
        chk("arst_data", out_data, '0);
        chk("arst_occ", 128'(occ), 128'(2'd0));
        chk("arst_ready", 128'(in_ready), 128'(1'b1));
        chk("arst_stall", 128'(stall_cnt), 128'(16'h0));
        in_valid = 1'b1; in_ctrl = 4'b0110; in_data = mk(40); out_ready = 1'b1;
        tick();
        chk("in_rst_valid", 128'(out_valid), 128'(1'b0));
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 128'(out_valid), 128'(1'b1));
        chk("post_rst_data", out_data, mk(40));
        chk("post_rst_ctrl", 128'(out_ctrl), 128'(4'b0110));
        in_valid = 1'b0;
        tick();
        chk("post_rst_empty", 128'(occ), 128'(2'd0));

        // stall counter saturation
        in_valid = 1'b1; in_ctrl = 4'b1001; in_data = mk(50); out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 128'(stall_cnt), 128'(16'hFFFE));
        tick();
        chk("sat_ffff", 128'(stall_cnt), 128'(16'hFFFF));
        repeat (4500) @(posedge clk);
        #1;
        chk("sat_hold", 128'(stall_cnt), 128'(16'hFFFF));
        chk("sat_data", out_data, mk(50));
        chk("sat_valid", 128'(out_valid), 128'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
